// File: rtl/data_reg_mux.sv
// Selects one of NUM_SRC valid/ready sources into a single holding register,
// by fixed index or round-robin, and tags each captured word with its source.
module data_reg_mux #(
  parameter int  WIDTH   = 128,
  parameter int  NUM_SRC = 2,
  localparam int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode_rr,
  input  logic [SRC_W-1:0]         sel,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]       src_valid,
  output logic [NUM_SRC-1:0]       src_ready,
  output logic [WIDTH-1:0]         data_reg_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SRC_W-1:0]         out_src,
  output logic [15:0]              load_count
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SRC_W-1:0] src_q;
  logic [SRC_W-1:0] last_grant_q;
  logic             valid_q;
  logic [15:0]      count_q, count_d;

  logic             can_accept;
  logic             gnt_vld;
  logic [SRC_W-1:0] gnt_idx;
  logic [SRC_W-1:0] rr_idx;
  logic             load;

  assign can_accept = !valid_q || out_ready;

  // Fixed mode: an out-of-range sel simply matches no source.
  // Round-robin: scan starting one past the last granted source.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_idx  = '0;
    if (!mode_rr) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (sel == SRC_W'(i) && src_valid[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = SRC_W'(i);
        end
      end
    end else begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        rr_idx = SRC_W'((int'(last_grant_q) + k) % NUM_SRC);
        if (!gnt_vld && src_valid[rr_idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = rr_idx;
        end
      end
    end
  end

  assign load = gnt_vld && can_accept && !rst;

  always_comb begin
    src_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = load && (gnt_idx == SRC_W'(i));
    end
  end

  always_comb begin
    data_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt_idx == SRC_W'(i)) data_d = src_data[i*WIDTH +: WIDTH];
    end
  end

  assign count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q       <= '0;
      src_q        <= '0;
      valid_q      <= 1'b0;
      count_q      <= '0;
      last_grant_q <= SRC_W'(NUM_SRC - 1);
    end else if (load) begin
      data_q       <= data_d;
      src_q        <= gnt_idx;
      valid_q      <= 1'b1;
      count_q      <= count_d;
      last_grant_q <= gnt_idx;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign data_reg_out = data_q;
  assign out_valid    = valid_q;
  assign out_src      = src_q;
  assign load_count   = count_q;

endmodule

// File: tb/tb_data_reg_mux.sv
// Directed bench for data_reg_mux: a 2-source 128-bit instance and a
// 3-source 16-bit instance, each task checking its own expected values.
module tb_data_reg_mux;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // 2-source instance
  logic         a_mode, a_sel, a_oready, a_ovalid, a_osrc;
  logic [255:0] a_data;
  logic [1:0]   a_valid, a_ready;
  logic [127:0] a_out;
  logic [15:0]  a_cnt;

  data_reg_mux #(.WIDTH(128), .NUM_SRC(2)) u2 (
    .clk(clk), .rst(rst), .mode_rr(a_mode), .sel(a_sel),
    .src_data(a_data), .src_valid(a_valid), .src_ready(a_ready),
    .data_reg_out(a_out), .out_valid(a_ovalid), .out_ready(a_oready),
    .out_src(a_osrc), .load_count(a_cnt)
  );

  // 3-source instance
  logic        b_mode, b_oready, b_ovalid;
  logic [1:0]  b_sel, b_osrc;
  logic [47:0] b_data;
  logic [2:0]  b_valid, b_ready;
  logic [15:0] b_out;
  logic [15:0] b_cnt;

  data_reg_mux #(.WIDTH(16), .NUM_SRC(3)) u3 (
    .clk(clk), .rst(rst), .mode_rr(b_mode), .sel(b_sel),
    .src_data(b_data), .src_valid(b_valid), .src_ready(b_ready),
    .data_reg_out(b_out), .out_valid(b_ovalid), .out_ready(b_oready),
    .out_src(b_osrc), .load_count(b_cnt)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_mode = 1'b0; a_sel = 1'b0; a_valid = 2'b11; a_oready = 1'b1;
    a_data = {128'd74, 128'd69};
    b_mode = 1'b1; b_sel = 2'd0; b_valid = 3'b111; b_oready = 1'b1;
    b_data = {16'd102, 16'd101, 16'd100};
    #1;
    checks++;
    if (a_ready !== 2'b00) begin
      failures++; $display("FAIL reset_ready2 got=%b exp=00", a_ready);
    end
    checks++;
    if (b_ready !== 3'b000) begin
      failures++; $display("FAIL reset_ready3 got=%b exp=000", b_ready);
    end
    step();
    step();
    checks++;
    if (a_ovalid !== 1'b0 || a_out !== 128'd0 || a_osrc !== 1'b0 || a_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_state2 got v=%b d=%0d s=%0d c=%0d exp 0/0/0/0", a_ovalid, a_out, a_osrc, a_cnt);
    end
    checks++;
    if (b_ovalid !== 1'b0 || b_out !== 16'd0 || b_osrc !== 2'd0 || b_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_state3 got v=%b d=%0d s=%0d c=%0d exp 0/0/0/0", b_ovalid, b_out, b_osrc, b_cnt);
    end
    b_valid = 3'b000;
    a_valid = 2'b00;
    rst = 1'b0;
    step();
  endtask

  task automatic test_fixed();
    a_mode = 1'b0; a_sel = 1'b0; a_valid = 2'b11; a_oready = 1'b1;
    #1;
    checks++;
    if (a_ready !== 2'b01) begin
      failures++; $display("FAIL fixed_ready_sel0 got=%b exp=01", a_ready);
    end
    step();
    checks++;
    if (a_out !== 128'd69 || a_osrc !== 1'b0 || a_ovalid !== 1'b1 || a_cnt !== 16'd1) begin
      failures++;
      $display("FAIL fixed_load_sel0 got d=%0d s=%0d v=%b c=%0d exp 69/0/1/1", a_out, a_osrc, a_ovalid, a_cnt);
    end
    a_sel = 1'b1;
    #1;
    checks++;
    if (a_ready !== 2'b10) begin
      failures++; $display("FAIL fixed_ready_sel1 got=%b exp=10", a_ready);
    end
    step();
    checks++;
    if (a_out !== 128'd74 || a_osrc !== 1'b1 || a_ovalid !== 1'b1 || a_cnt !== 16'd2) begin
      failures++;
      $display("FAIL fixed_load_sel1 got d=%0d s=%0d v=%b c=%0d exp 74/1/1/2", a_out, a_osrc, a_ovalid, a_cnt);
    end
    a_valid = 2'b00;
    step();
    checks++;
    if (a_ovalid !== 1'b0 || a_out !== 128'd74 || a_osrc !== 1'b1 || a_cnt !== 16'd2) begin
      failures++;
      $display("FAIL fixed_consume got v=%b d=%0d s=%0d c=%0d exp 0/74/1/2", a_ovalid, a_out, a_osrc, a_cnt);
    end
  endtask

  task automatic test_stall();
    a_sel = 1'b0; a_valid = 2'b11; a_oready = 1'b0;
    #1;
    checks++;
    if (a_ready !== 2'b01) begin
      failures++; $display("FAIL stall_empty_ready got=%b exp=01", a_ready);
    end
    step();
    checks++;
    if (a_out !== 128'd69 || a_ovalid !== 1'b1 || a_cnt !== 16'd3) begin
      failures++;
      $display("FAIL stall_fill got d=%0d v=%b c=%0d exp 69/1/3", a_out, a_ovalid, a_cnt);
    end
    a_sel = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1;
      checks++;
      if (a_ready !== 2'b00) begin
        failures++; $display("FAIL stall_ready cyc=%0d got=%b exp=00", n, a_ready);
      end
      step();
      checks++;
      if (a_out !== 128'd69 || a_osrc !== 1'b0 || a_ovalid !== 1'b1 || a_cnt !== 16'd3) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got d=%0d s=%0d v=%b c=%0d exp 69/0/1/3", n, a_out, a_osrc, a_ovalid, a_cnt);
      end
    end
    a_oready = 1'b1;
    #1;
    checks++;
    if (a_ready !== 2'b10) begin
      failures++; $display("FAIL stall_release_ready got=%b exp=10", a_ready);
    end
    step();
    checks++;
    if (a_out !== 128'd74 || a_osrc !== 1'b1 || a_ovalid !== 1'b1 || a_cnt !== 16'd4) begin
      failures++;
      $display("FAIL back_to_back got d=%0d s=%0d v=%b c=%0d exp 74/1/1/4", a_out, a_osrc, a_ovalid, a_cnt);
    end
    a_valid = 2'b00;
    step();
  endtask

  task automatic test_rr();
    logic [1:0] exp_src;
    b_mode = 1'b1; b_valid = 3'b111; b_oready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      exp_src = 2'(n % 3);
      step();
      checks++;
      if (b_osrc !== exp_src || b_out !== 16'(100 + n % 3) || b_ovalid !== 1'b1) begin
        failures++;
        $display("FAIL rr_seq n=%0d got s=%0d d=%0d v=%b exp s=%0d d=%0d v=1", n, b_osrc, b_out, b_ovalid, exp_src, 100 + n % 3);
      end
    end
    checks++;
    if (b_cnt !== 16'd6) begin
      failures++; $display("FAIL rr_count got=%0d exp=6", b_cnt);
    end
    // last grant is now 2
    b_valid = 3'b100;
    step();
    checks++;
    if (b_osrc !== 2'd2 || b_out !== 16'd102) begin
      failures++; $display("FAIL rr_sparse_a got s=%0d d=%0d exp 2/102", b_osrc, b_out);
    end
    b_valid = 3'b101;
    #1;
    checks++;
    if (b_ready !== 3'b001) begin
      failures++; $display("FAIL rr_sparse_ready got=%b exp=001", b_ready);
    end
    step();
    checks++;
    if (b_osrc !== 2'd0 || b_out !== 16'd100) begin
      failures++; $display("FAIL rr_sparse_b got s=%0d d=%0d exp 0/100", b_osrc, b_out);
    end
    step();
    checks++;
    if (b_osrc !== 2'd2 || b_out !== 16'd102 || b_cnt !== 16'd9) begin
      failures++; $display("FAIL rr_sparse_c got s=%0d d=%0d c=%0d exp 2/102/9", b_osrc, b_out, b_cnt);
    end
  endtask

  task automatic test_sel_out_of_range();
    b_mode = 1'b0; b_sel = 2'd3; b_valid = 3'b111; b_oready = 1'b1;
    #1;
    checks++;
    if (b_ready !== 3'b000) begin
      failures++; $display("FAIL oor_ready got=%b exp=000", b_ready);
    end
    step();
    checks++;
    if (b_ovalid !== 1'b0 || b_out !== 16'd102 || b_osrc !== 2'd2 || b_cnt !== 16'd9) begin
      failures++;
      $display("FAIL oor_consume got v=%b d=%0d s=%0d c=%0d exp 0/102/2/9", b_ovalid, b_out, b_osrc, b_cnt);
    end
  endtask

  task automatic test_reset_mid();
    b_mode = 1'b1; b_valid = 3'b111; b_oready = 1'b0;
    step();
    checks++;
    if (b_ovalid !== 1'b1 || b_osrc !== 2'd0 || b_out !== 16'd100) begin
      failures++; $display("FAIL mid_fill got v=%b s=%0d d=%0d exp 1/0/100", b_ovalid, b_osrc, b_out);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (b_ovalid !== 1'b0 || b_out !== 16'd0 || b_cnt !== 16'd0 || b_osrc !== 2'd0) begin
      failures++;
      $display("FAIL mid_reset got v=%b d=%0d c=%0d s=%0d exp 0/0/0/0", b_ovalid, b_out, b_cnt, b_osrc);
    end
    b_oready = 1'b1;
    #1;
    checks++;
    if (b_ready !== 3'b001) begin
      failures++; $display("FAIL mid_first_ready got=%b exp=001", b_ready);
    end
    step();
    checks++;
    if (b_osrc !== 2'd0 || b_out !== 16'd100 || b_cnt !== 16'd1) begin
      failures++; $display("FAIL mid_first_grant got s=%0d d=%0d c=%0d exp 0/100/1", b_osrc, b_out, b_cnt);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fixed();
    test_stall();
    test_rr();
    test_sel_out_of_range();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
